vga_pixel_sink: RTL and testbench

- Consumer end of the drawer pixel-write stream (x, y, colour, write) used by the screen drawer/eraser blocks.
- Bounds-checks each pixel, buffers it in a small FIFO and converts it to a linear framebuffer address.
- Drains to a single-port framebuffer RAM through a valid/ready write handshake; reports frame completion and idle.

---
 rtl/vga_pixel_sink.sv | 233 +++++++++++++++++++++++
 tb/tb_vga_pixel_sink.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_sink.sv
// -----------------------------------------------------------------------------
// vga_pixel_sink
//
// Receives the drawer pixel-write stream, which carries (x, y, colour, write).
// Each pixel is bounds-checked and converted to a linear framebuffer address
// (y*160 + x). It is then queued in a small FIFO and drained to a single-port
// framebuffer through a valid/ready write handshake.
//
// Optional build macro:
//   VGA_PIXEL_SINK_DUPSUPPRESS_EN - when this macro is defined, a pushed pixel
//       whose address and colour both equal the most recently pushed entry is
//       dropped silently. The comparison register is invalidated when the
//       last pixel of a frame is committed.
//
// Ports:
//   clk         clock; all logic runs on the rising edge
//   resetn      synchronous, active-low reset
//   x_in        pixel column (8 bit)
//   y_in        pixel row (7 bit)
//   colour_in   pixel colour {R,G,B}
//   write_in    pixel valid from the drawer
//   in_ready    sink can accept a pixel this cycle
//   mem_we      framebuffer write request (valid)
//   mem_addr    linear framebuffer address
//   mem_data    colour to write
//   mem_ready   framebuffer accepts the request this cycle
//   clip_err    one-cycle pulse: an out-of-range pixel was dropped
//   frame_done  one-cycle pulse: pixel (XMAX,YMAX) was committed to memory
//   idle        FIFO empty and no pending memory request
// -----------------------------------------------------------------------------
module vga_pixel_sink #(
    parameter int DEPTH = 4,
    parameter int XMAX  = 159,
    parameter int YMAX  = 119
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  x_in,
    input  logic [6:0]  y_in,
    input  logic [2:0]  colour_in,
    input  logic        write_in,
    output logic        in_ready,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    input  logic        mem_ready,
    output logic        clip_err,
    output logic        frame_done,
    output logic        idle
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [7:0]    XMAX_C    = 8'(XMAX);
    localparam logic [6:0]    YMAX_C    = 7'(YMAX);
    localparam logic [14:0]   LAST_ADDR = 15'(YMAX * 160 + XMAX);

    // ---------------------------------------------------------------------
    // FIFO storage and control state
    // ---------------------------------------------------------------------
    logic [14:0]   fifo_addr [DEPTH];
    logic [2:0]    fifo_col  [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    // Output stage registers
    logic          mem_we_q,   mem_we_d;
    logic [14:0]   mem_addr_q, mem_addr_d;
    logic [2:0]    mem_data_q, mem_data_d;

    // Status pulse registers
    logic          clip_err_q,   clip_err_d;
    logic          frame_done_q, frame_done_d;

    // ---------------------------------------------------------------------
    // Input side
    // ---------------------------------------------------------------------
    logic          accept;
    logic          in_range;
    logic [14:0]   pix_addr;
    logic          dup_hit;
    logic          push;

    assign in_ready = (count_q < DEPTH_C);
    assign accept   = write_in & in_ready;
    assign in_range = (x_in <= XMAX_C) && (y_in <= YMAX_C);

    // y*160 + x written as y*128 + y*32 + x, so that no multiplier is inferred
    assign pix_addr = {1'b0, y_in, 7'b0} + {3'b0, y_in, 5'b0} + {7'b0, x_in};

`ifdef VGA_PIXEL_SINK_DUPSUPPRESS_EN
    logic          last_valid_q, last_valid_d;
    logic [14:0]   last_addr_q,  last_addr_d;
    logic [2:0]    last_col_q,   last_col_d;

    assign dup_hit = last_valid_q && (last_addr_q == pix_addr)
                     && (last_col_q == colour_in);
`else
    assign dup_hit = 1'b0;
`endif

    assign push = accept & in_range & ~dup_hit;

    // ---------------------------------------------------------------------
    // Output side
    // ---------------------------------------------------------------------
    logic          transfer;
    logic          fifo_empty;
    logic          pop;

    assign transfer   = mem_we_q & mem_ready;
    assign fifo_empty = (count_q == '0);

    // The stage is refilled when it is empty or when it is being emptied this
    // cycle. A pixel that is pushed in the same cycle cannot be popped yet,
    // which gives one cycle of latency from acceptance to mem_we.
    assign pop = (~mem_we_q | transfer) & ~fifo_empty;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        clip_err_d   = accept & ~in_range;
        frame_done_d = transfer && (mem_addr_q == LAST_ADDR);

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = fifo_addr[rd_ptr_q];
            mem_data_d = fifo_col[rd_ptr_q];
        end else if (transfer) begin
            mem_we_d = 1'b0;
        end

        // A push and a pop in the same cycle leave the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

`ifdef VGA_PIXEL_SINK_DUPSUPPRESS_EN
    always_comb begin
        last_valid_d = last_valid_q;
        last_addr_d  = last_addr_q;
        last_col_d   = last_col_q;
        if (push) begin
            last_valid_d = 1'b1;
            last_addr_d  = pix_addr;
            last_col_d   = colour_in;
        end else if (frame_done_d) begin
            // A new frame may legitimately redraw the same pixel.
            last_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_valid_q <= 1'b0;
            last_addr_q  <= '0;
            last_col_q   <= '0;
        end else begin
            last_valid_q <= last_valid_d;
            last_addr_q  <= last_addr_d;
            last_col_q   <= last_col_d;
        end
    end
`endif

    // ---------------------------------------------------------------------
    // FIFO entry storage. The contents do not need a reset because the
    // pointers and the count define which entries are valid.
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PW'(gi))) begin
                    fifo_addr[gi] <= pix_addr;
                    fifo_col[gi]  <= colour_in;
                end
            end
        end
    endgenerate

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            clip_err_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            clip_err_q   <= clip_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign clip_err   = clip_err_q;
    assign frame_done = frame_done_q;
    assign idle       = fifo_empty & ~mem_we_q;

endmodule

// File: tb/tb_vga_pixel_sink.sv
// -----------------------------------------------------------------------------
// tb_vga_pixel_sink
//
// Self-checking bench for vga_pixel_sink. The reference model is a plain queue
// of pending {address, colour} pixels plus one output-slot variable. It is
// stepped once per clock according to the documented acceptance, clipping,
// and drain rules. Directed scenarios are followed by randomized traffic and a
// full-screen sweep.
// -----------------------------------------------------------------------------
module tb_vga_pixel_sink;

    localparam int DEPTH = 4;
    localparam int LAST  = 119 * 160 + 159;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  x_in;
    logic [6:0]  y_in;
    logic [2:0]  colour_in;
    logic        write_in;
    logic        in_ready;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_ready;
    logic        clip_err;
    logic        frame_done;
    logic        idle;

    always #5 clk = ~clk;

    vga_pixel_sink #(.DEPTH(DEPTH), .XMAX(159), .YMAX(119)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .write_in   (write_in),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .clip_err   (clip_err),
        .frame_done (frame_done),
        .idle       (idle)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_q[$];            // pending pixels, each stored as addr*8 + colour
    bit m_sv;              // output slot holds a request
    int m_sa, m_sd;        // address and colour of that request
    bit m_clip, m_done;
    bit m_rst_seen;        // the most recent edge was a reset edge
    bit m_lv;              // previous push is valid, for duplicate suppression
    int m_lpix;

    int  xfers, dones;
    bit  quiet;

    // Drive one cycle of inputs at the falling edge, advance the model across
    // the next rising edge, and compare all outputs #1 after that edge.
    task automatic step(input bit rstn, input bit wr, input int x, input int y,
                        input int c, input bit rdy, output bit acc);
        int xx, yy, cc, pix;
        bit inr, xfer, pop, push, dup;
        xx = x & 255; yy = y & 127; cc = c & 7;
        resetn = rstn; write_in = wr; x_in = xx[7:0]; y_in = yy[6:0];
        colour_in = cc[2:0]; mem_ready = rdy;
        #1;
        if (rstn && mem_we && rdy) begin
            xfers++;
            if (!quiet) $display("xfer addr=%0d data=%0d", mem_addr, mem_data);
        end
        acc = rstn && wr && (m_q.size() < DEPTH);
        @(posedge clk);
        #1;
        if (!rstn) begin
            m_q.delete(); m_sv = 0; m_sa = 0; m_sd = 0;
            m_clip = 0; m_done = 0; m_lv = 0; m_rst_seen = 1;
        end else begin
            m_rst_seen = 0;
            inr    = (xx <= 159) && (yy <= 119);
            pix    = (yy * 160 + xx) * 8 + cc;
            xfer   = m_sv && rdy;
            m_done = xfer && (m_sa == LAST);
            m_clip = acc && !inr;
            dup = 0;
`ifdef VGA_PIXEL_SINK_DUPSUPPRESS_EN
            dup = m_lv && (m_lpix == pix);
`endif
            push = acc && inr && !dup;
            pop  = (!m_sv || xfer) && (m_q.size() > 0);
            if (pop) begin
                pix  = m_q.pop_front();
                m_sv = 1; m_sa = pix / 8; m_sd = pix % 8;
                pix  = (yy * 160 + xx) * 8 + cc;
            end else if (xfer) begin
                m_sv = 0;
            end
            if (push) begin
                m_q.push_back(pix);
                m_lv = 1; m_lpix = pix;
            end else if (m_done) begin
                m_lv = 0;
            end
        end
        chk("mem_we", mem_we, m_sv);
        if (m_sv || m_rst_seen) begin
            chk("mem_addr", mem_addr, m_sa);
            chk("mem_data", mem_data, m_sd);
        end
        chk("in_ready", in_ready, m_q.size() < DEPTH);
        chk("idle", idle, (m_q.size() == 0) && !m_sv);
        chk("clip_err", clip_err, m_clip);
        chk("frame_done", frame_done, m_done);
        if (frame_done) dones++;
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int tries;
        resetn = 0; write_in = 0; x_in = 0; y_in = 0; colour_in = 0; mem_ready = 0;
        quiet = 0; xfers = 0; dones = 0;
        @(negedge clk);

        // Reset, then idle
        step(0, 0, 0, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, acc);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_idle", idle, 1);

        // Single pixel
        step(1, 1, 5, 2, 5, 1, acc);
        step(1, 0, 0, 0, 0, 1, acc);
        chk("single_we", mem_we, 1);
        chk("single_addr", mem_addr, 325);
        chk("single_data", mem_data, 5);
        step(1, 0, 0, 0, 0, 1, acc);
        step(1, 0, 0, 0, 0, 1, acc);
        chk("single_idle", idle, 1);

        // Backpressure until the sink is full
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 10 + i, 3, i, 0, acc);
            if (i == 5) chk("full_reject", acc, 0);
        end
        chk("full_in_ready", in_ready, 0);
        step(1, 1, 15, 3, 5, 0, acc);     // stalled: addr/data must hold
        tries = 0;
        do begin
            step(1, 1, 15, 3, 5, 1, acc);
            tries++;
        end while (!acc && tries < 20);
        chk("sixth_accepted", acc, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, ($urandom_range(0, 2) != 0), acc);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1, acc);

        // Clipping at both edges
        step(1, 1, 160, 0, 3, 1, acc);
        step(1, 0, 0, 0, 0, 1, acc);
        step(1, 1, 0, 120, 3, 1, acc);
        step(1, 0, 0, 0, 0, 1, acc);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7),
                 $urandom_range(150, 170) - (($urandom_range(0, 1) != 0) ? 150 : 0),
                 $urandom_range(110, 127) - (($urandom_range(0, 1) != 0) ? 110 : 0),
                 $urandom_range(0, 7), ($urandom_range(0, 3) != 0), acc);
        end
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 1, acc);

        // Reset in the middle of a stall
        for (int i = 0; i < 3; i++) step(1, 1, 20 + i, 7, i + 1, 0, acc);
        step(0, 0, 0, 0, 0, 0, acc);
        chk("midrst_we", mem_we, 0);
        chk("midrst_idle", idle, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1, acc);

        // Full-screen sweep
        quiet = 1; xfers = 0; dones = 0;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) step(1, 1, x, y, (x + y) & 7, 1, acc);
            $display("sweep row %0d written", y);
        end
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 1, acc);
        chk("sweep_xfers", xfers, 19200);
        chk("sweep_frame_done", dones, 1);
        chk("sweep_idle", idle, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
